frv_alu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared single-cycle execute ALU. Port 0 is the pipeline execute stage. Port 1 is an auxiliary requester (e.g. crypto/CSR helper). The block decodes a compact opcode into the ALU's one-hot op lines and drives the ALU operands. It registers the ALU result into a single-entry response buffer and returns it to the owning port over a valid/ready channel.

---
 rtl/frv_alu_arb.sv | 105 ++++++++++
 tb/tb_frv_alu_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/frv_alu_arb.sv
// Two-port arbiter/sequencer for the shared single-cycle execute ALU.
// Decodes the granted opcode to one-hot ALU ops and buffers one result for its owner.
module frv_alu_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_LIM = 4,
  parameter int OPW        = 6
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_opr_a,
  input  logic [XLEN-1:0] req0_opr_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_opr_a,
  input  logic [XLEN-1:0] req1_opr_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_err,
  output logic [XLEN-1:0] alu_opr_a,
  output logic [XLEN-1:0] alu_opr_b,
  output logic [4:0]      alu_shamt,
  output logic [35:0]     alu_op,
  input  logic [XLEN-1:0] alu_result
);

  localparam int SCW    = $clog2(STARVE_LIM + 1);
  localparam int NUM_OP = 36;

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  req_t           req [2];
  logic           full, owner;
  logic [SCW-1:0] starve_cnt;
  logic           can_accept, grant0, grant1, any_grant, legal;
  req_t           g_req;

  assign req[0] = '{valid: req0_valid, op: req0_op, a: req0_opr_a, b: req0_opr_b};
  assign req[1] = '{valid: req1_valid, op: req1_op, a: req1_opr_a, b: req1_opr_b};

  // Drain and refill in the same cycle when the current owner is consuming.
  assign can_accept = g_resetn & (~full | (owner ? rsp1_ready : rsp0_ready));
  assign grant1     = can_accept & req[1].valid &
                      ((starve_cnt == SCW'(STARVE_LIM)) | ~req[0].valid);
  assign grant0     = can_accept & req[0].valid & ~grant1;
  assign any_grant  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign g_req = grant1 ? req[1] : req[0];
  assign legal = g_req.op < OPW'(NUM_OP);

  // Operands are forced to zero when idle or illegal so the ALU does not toggle.
  always_comb begin
    alu_op    = '0;
    alu_opr_a = '0;
    alu_opr_b = '0;
    alu_shamt = '0;
    if (any_grant && legal) begin
      alu_op    = 36'(1) << g_req.op;
      alu_opr_a = g_req.a;
      alu_opr_b = g_req.b;
      alu_shamt = g_req.b[4:0];
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      full       <= 1'b0;
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (any_grant) begin
        full       <= 1'b1;
        owner      <= grant1;
        rsp_result <= legal ? alu_result : '0;
        rsp_err    <= ~legal;
      end else if (full && (owner ? rsp1_ready : rsp0_ready)) begin
        full <= 1'b0;
      end
      // Counter only moves on a real arbitration outcome; a blocked buffer holds it.
      if (grant1 || !req[1].valid)
        starve_cnt <= '0;
      else if (grant0 && starve_cnt != SCW'(STARVE_LIM))
        starve_cnt <= starve_cnt + SCW'(1);
    end
  end

  assign rsp0_valid = full & ~owner;
  assign rsp1_valid = full &  owner;

endmodule

// File: tb/tb_frv_alu_arb.sv
// Directed bench for frv_alu_arb with a small behavioural ALU on the alu_* interface.
module tb_frv_alu_arb;
  logic        g_clk = 0, g_resetn = 0;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [5:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_opr_a = 0, req0_opr_b = 0, req1_opr_a = 0, req1_opr_b = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err;
  logic [31:0] rsp_result, alu_opr_a, alu_opr_b, alu_result;
  logic [4:0]  alu_shamt;
  logic [35:0] alu_op;
  int errors = 0, checks = 0;

  frv_alu_arb dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_opr_a(req0_opr_a), .req0_opr_b(req0_opr_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_opr_a(req1_opr_a), .req1_opr_b(req1_opr_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_opr_a(alu_opr_a), .alu_opr_b(alu_opr_b), .alu_shamt(alu_shamt),
    .alu_op(alu_op), .alu_result(alu_result));

  always #5 g_clk = ~g_clk;

  // External ALU: only the ops exercised here.
  function automatic logic [31:0] alu_model(logic [35:0] op, logic [31:0] a, logic [31:0] b,
                                            logic [4:0] sh);
    logic [31:0] r;
    r = 32'd0;
    if (op[0])  r = a + b;
    if (op[2])  r = a ^ b;
    if (op[8])  r = a << sh;
    if (op[21]) begin
      r = 32'd32;
      for (int i = 0; i < 32; i++) if (a[i]) r = 32'(31 - i);
    end
    return r;
  endfunction

  assign alu_result = alu_model(alu_op, alu_opr_a, alu_opr_b, alu_shamt);

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
  endtask

  // Both ports request every cycle; port1 must win exactly on the 5th cycle.
  task automatic starve_run(input string tag);
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = 6'd0; req0_opr_a = 32'd1;        req0_opr_b = 32'd2;
    req1_valid = 1; req1_op = 6'd2; req1_opr_a = 32'hF0F0F0F0; req1_opr_b = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk({tag, "_r0"}, 64'(req0_ready), 64'(i != 4));
      chk({tag, "_r1"}, 64'(req1_ready), 64'(i == 4));
      @(negedge g_clk);
      if (i == 4) begin
        chk({tag, "_v1"}, 64'(rsp1_valid), 64'd1);
        chk({tag, "_res1"}, 64'(rsp_result), 64'h0F0F0F0F);
      end else begin
        chk({tag, "_v0"}, 64'(rsp0_valid), 64'd1);
        chk({tag, "_res0"}, 64'(rsp_result), 64'd3);
      end
    end
    idle();
    @(negedge g_clk);
    chk({tag, "_drained"}, 64'({rsp0_valid, rsp1_valid}), 64'd0);
  endtask

  initial begin
    // Reset state
    @(negedge g_clk); #1;
    chk("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_result", 64'({rsp_err, rsp_result}), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    @(negedge g_clk); g_resetn = 1;
    @(negedge g_clk);

    // Single add on port0
    rsp0_ready = 1;
    req0_valid = 1; req0_op = 6'd0; req0_opr_a = 32'd5; req0_opr_b = 32'd7;
    #1;
    chk("add_ready0", 64'(req0_ready), 64'd1);
    chk("add_ready1", 64'(req1_ready), 64'd0);
    chk("add_alu_op", 64'(alu_op), 64'd1);
    chk("add_opr_a", 64'(alu_opr_a), 64'd5);
    @(negedge g_clk); idle();
    chk("add_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'b10);
    chk("add_result", 64'(rsp_result), 64'd12);
    chk("add_err", 64'(rsp_err), 64'd0);
    @(negedge g_clk);
    chk("add_drain", 64'(rsp0_valid), 64'd0);

    starve_run("starve");

    // Backpressure on port0 blocks both ports
    rsp0_ready = 0; rsp1_ready = 1;
    req0_valid = 1; req0_op = 6'd0; req0_opr_a = 32'd10; req0_opr_b = 32'd20;
    #1 chk("bp_accept", 64'(req0_ready), 64'd1);
    @(negedge g_clk);
    idle();
    req1_valid = 1; req1_op = 6'd2; req1_opr_a = 32'd3; req1_opr_b = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 64'({req0_ready, req1_ready}), 64'd0);
      chk("bp_hold", 64'({rsp0_valid, rsp_result}), {31'd0, 1'b1, 32'd30});
      @(negedge g_clk);
    end
    rsp0_ready = 1;
    #1 chk("bp_refill_ready1", 64'(req1_ready), 64'd1);
    @(negedge g_clk); idle();
    chk("bp_owner", 64'({rsp0_valid, rsp1_valid}), 64'b01);
    chk("bp_result", 64'(rsp_result), 64'd6);
    @(negedge g_clk);

    // Illegal opcode on port1
    req1_valid = 1; req1_op = 6'd40; req1_opr_a = 32'hDEAD; req1_opr_b = 32'hBEEF;
    #1;
    chk("ill_ready1", 64'(req1_ready), 64'd1);
    chk("ill_alu_op", 64'(alu_op), 64'd0);
    chk("ill_opr_a", 64'(alu_opr_a), 64'd0);
    @(negedge g_clk); idle();
    chk("ill_valid1", 64'(rsp1_valid), 64'd1);
    chk("ill_err_res", 64'({rsp_err, rsp_result}), {31'd0, 1'b1, 32'd0});
    @(negedge g_clk);

    // sll via shamt, then back-to-back clz
    req0_valid = 1; req0_op = 6'd8; req0_opr_a = 32'd1; req0_opr_b = 32'h23;
    #1;
    chk("sll_shamt", 64'(alu_shamt), 64'd3);
    chk("sll_alu_op", 64'(alu_op), 64'd1 << 8);
    @(negedge g_clk);
    chk("sll_result", 64'(rsp_result), 64'd8);
    req0_op = 6'd21; req0_opr_a = 32'h00010000; req0_opr_b = 32'd0;
    #1 chk("clz_ready", 64'(req0_ready), 64'd1);
    @(negedge g_clk); idle();
    chk("clz_result", 64'({rsp0_valid, rsp_err, rsp_result}), {31'd0, 2'b10, 32'd15});
    @(negedge g_clk);

    // Reset while full
    rsp0_ready = 0;
    req0_valid = 1; req0_op = 6'd0; req0_opr_a = 32'd1; req0_opr_b = 32'd1;
    @(negedge g_clk); idle();
    chk("rstm_full", 64'(rsp0_valid), 64'd1);
    g_resetn = 0;
    #1;
    chk("rstm_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("rstm_result", 64'({rsp_err, rsp_result}), 64'd0);
    @(negedge g_clk); g_resetn = 1;
    @(negedge g_clk);
    chk("rstm_stale", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    starve_run("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
